imem_loader: RTL and testbench

- Boot-time writer for the instruction memory; the write-side counterpart of the core's fetch path, which only reads imem.
- Accepts a byte stream over a valid/ready interface. The stream carries a 4-byte word count, then the payload words, then a checksum byte.
- Assembles the bytes into 32-bit words and writes them into imem at consecutive word addresses.
- Holds the core in reset until a complete, checksum-valid image has been written, then releases it.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer; the first beat of a word lands in bits [7:0].
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        beat_valid,
    input  logic [7:0]  beat_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] sh;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sh  <= '0;
        end else if (beat_valid) begin
            cnt <= cnt + 2'd1;
            sh  <= {beat_data, sh[23:8]};
        end
    end

    // The completing beat is forwarded directly so the word is available in the same cycle.
    assign word_valid = beat_valid && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {beat_data, sh};

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: streams a counted, checksummed image into imem and then releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned NUMWORDS  = 4096,
    parameter int unsigned DATAWIDTH = 32,
    parameter logic [31:0] BASEADDR  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 s_valid_i,
    input  logic [7:0]           s_data_i,
    output logic                 s_ready_o,
    output logic                 we_o,
    output logic [31:0]          waddr_o,
    output logic [DATAWIDTH-1:0] wdata_o,
    output logic                 core_rst_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    state_t      state, state_nxt;
    logic        accept;
    logic        load_start;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic [31:0] count;
    logic [31:0] word_cnt;
    logic [7:0]  csum;

    assign accept     = s_valid_i && s_ready_o;
    assign load_start = start_i && (state == IDLE || state == DONE || state == ERROR);

    imem_loader_byte_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clr        (load_start),
        .beat_valid (accept && (state == HDR || state == DATA)),
        .beat_data  (s_data_i),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s_ready_o  = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        core_rst_o = 1'b1;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = HDR;
            end
            HDR: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b1;
                if (pk_valid) begin
                    if (pk_word > 32'(NUMWORDS)) state_nxt = ERROR;
                    else if (pk_word == '0)      state_nxt = CSUM;
                    else                         state_nxt = DATA;
                end
            end
            DATA: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b1;
                if (pk_valid && (word_cnt + 32'd1 == count)) state_nxt = CSUM;
            end
            CSUM: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b1;
                if (accept) state_nxt = (s_data_i == csum) ? DONE : ERROR;
            end
            DONE: begin
                done_o     = 1'b1;
                core_rst_o = 1'b0;
                if (start_i) state_nxt = HDR;
            end
            ERROR: begin
                err_o = 1'b1;
                if (start_i) state_nxt = HDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes are registered, so the last data write lands in the first CSUM cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count    <= '0;
            word_cnt <= '0;
            csum     <= '0;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            we_o <= 1'b0;
            if (load_start) begin
                word_cnt <= '0;
                csum     <= '0;
            end
            if (state == HDR && pk_valid) count <= pk_word;
            if (state == DATA && accept)  csum  <= csum ^ s_data_i;
            if (state == DATA && pk_valid) begin
                we_o     <= 1'b1;
                waddr_o  <= BASEADDR + {word_cnt[29:0], 2'b00};
                wdata_o  <= pk_word;
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus hand-written corner sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_ready_o  (s_ready),
        .we_o       (we),
        .waddr_o    (waddr),
        .wdata_o    (wdata),
        .core_rst_o (core_rst),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [13];
        int unsigned n;
        bit          gap;
        bit          ok;
        int unsigned nwr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs [4];
    wr_t  exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge and every write checked against the scoreboard.
    task automatic step();
        wr_t w;
        @(posedge clk);
        #1;
        if (we === 1'b1) begin
            check("we_single_cycle", {31'b0, prev_we}, 32'd0);
            check("core_rst_during_write", {31'b0, core_rst}, 32'd1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", waddr, wdata);
            end else begin
                w = exp_q.pop_front();
                check("waddr", waddr, w.a);
                check("wdata", wdata, w.d);
            end
        end
        prev_we = we;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        bit rdy;
        if (gap) begin
            s_valid = 1'b0;
            step();
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int k = 0; k < 20; k++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: got s_ready 0 for 20 cycles expected 1");
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_case(input int idx);
        if (vecs[idx].nwr > 0) exp_q.push_back('{a: 32'h0, d: vecs[idx].w0});
        if (vecs[idx].nwr > 1) exp_q.push_back('{a: 32'h4, d: vecs[idx].w1});
        pulse_start();
        for (int unsigned i = 0; i < vecs[idx].n; i++) send(vecs[idx].b[i], vecs[idx].gap);
        repeat (3) step();
        check("done", {31'b0, done}, {31'b0, vecs[idx].ok});
        check("err", {31'b0, err}, {31'b0, !vecs[idx].ok});
        check("core_rst", {31'b0, core_rst}, {31'b0, !vecs[idx].ok});
        check("busy", {31'b0, busy}, 32'd0);
        check("s_ready", {31'b0, s_ready}, 32'd0);
        check("writes_missing", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_waddr", waddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A},
                    n: 13, gap: 1'b0, ok: 1'b1, nwr: 2, w0: 32'h12345678, w1: 32'hDEADBEEF};
        vecs[1] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B},
                    n: 13, gap: 1'b0, ok: 1'b0, nwr: 2, w0: 32'h12345678, w1: 32'hDEADBEEF};
        vecs[2] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A},
                    n: 13, gap: 1'b1, ok: 1'b1, nwr: 2, w0: 32'h12345678, w1: 32'hDEADBEEF};
        vecs[3] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 5, gap: 1'b0, ok: 1'b1, nwr: 0, w0: 32'h0, w1: 32'h0};

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_values();

        run_case(0);
        run_case(1);

        // Oversize header: ERROR must be visible right after the 4th header byte.
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check("oversize_err", {31'b0, err}, 32'd1);
        check("oversize_busy", {31'b0, busy}, 32'd0);
        check("oversize_s_ready", {31'b0, s_ready}, 32'd0);
        check("oversize_core_rst", {31'b0, core_rst}, 32'd1);
        repeat (3) step();
        check("oversize_writes", exp_q.size(), 32'd0);

        run_case(2);
        run_case(3);

        // Reset after 6 payload bytes: one word written, partial second word discarded.
        exp_q.push_back('{a: 32'h0, d: 32'h12345678});
        pulse_start();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h78, 1'b0);
        send(8'h56, 1'b0);
        send(8'h34, 1'b0);
        send(8'h12, 1'b0);
        send(8'hEF, 1'b0);
        send(8'hBE, 1'b0);
        check("midload_writes", exp_q.size(), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        step();
        check_reset_values();
        rst = 1'b0;
        step();
        run_case(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
